// File: rtl/m68k_mem_responder.sv
// m68k_mem_responder: 68000-style bus slave that serves CPU cycles from the
// low program ROM, the high program ROM and an on-chip work RAM.
// It decodes the address, honours the UDS_b/LDS_b byte strobes and inserts
// programmable wait states. It acknowledges a mapped access with DTACK_b and
// signals an unmapped access with BERR_b once a timeout expires.
//
// Ports (all logic runs on posedge MCKR; reset is synchronous, active-high):
//   MCKR, reset                 clock and reset
//   addr[22:0]                  CPU word address A23..A1
//   AS_b, UDS_b, LDS_b          address strobe and byte strobes (active low)
//   BR_W_b                      1 = read, 0 = write
//   DATA_in[15:0]               CPU write data
//   DATA_out[15:0]              registered read data
//   DTACK_b, BERR_b             registered acknowledge and bus error (active low)
//   rom_addr[16:0], rom_sel_h   registered ROM BRAM word index and bank select
//   rom_en                      registered ROM BRAM read enable
//   rom_data[15:0]              ROM BRAM output, valid one cycle after rom_en
//
// Optional feature: define ROM_WRITE_TRAP_EN to send writes to either ROM region
// down the bus-error path. When it is undefined, ROM writes are acknowledged and
// then discarded.

module m68k_mem_responder #(
    parameter int unsigned ROM_WAIT   = 1,
    parameter int unsigned RAM_WAIT   = 1,
    parameter logic [22:0] RAM_BASE   = 23'h200000,
    parameter int unsigned RAM_AWIDTH = 12,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        MCKR,
    input  logic        reset,
    input  logic [22:0] addr,
    input  logic        AS_b,
    input  logic        UDS_b,
    input  logic        LDS_b,
    input  logic        BR_W_b,
    input  logic [15:0] DATA_in,
    output logic [15:0] DATA_out,
    output logic        DTACK_b,
    output logic        BERR_b,
    output logic [16:0] rom_addr,
    output logic        rom_sel_h,
    output logic        rom_en,
    input  logic [15:0] rom_data
);

    localparam int unsigned WAIT_MAX  = (ROM_WAIT > RAM_WAIT) ? ROM_WAIT : RAM_WAIT;
    localparam int unsigned CNT_MAX   = (TIMEOUT > WAIT_MAX) ? TIMEOUT : WAIT_MAX;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned RAM_DEPTH = 1 << RAM_AWIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_ERR,
        S_BERR
    } state_e;

    typedef enum logic [1:0] {
        R_ROM_L,
        R_ROM_H,
        R_RAM,
        R_UNMAP
    } region_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    region_e                 region_q, region_d;
    logic                    rnw_q, rnw_d;
    logic                    uds_q, uds_d;
    logic                    lds_q, lds_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [RAM_AWIDTH-1:0]   ram_idx_q, ram_idx_d;
    logic                    dtack_b_q, dtack_b_d;
    logic                    berr_b_q, berr_b_d;
    logic [15:0]             data_out_q, data_out_d;
    logic                    rom_en_q, rom_en_d;
    logic [16:0]             rom_addr_q, rom_addr_d;
    logic                    rom_sel_h_q, rom_sel_h_d;

    region_e                 region_c;
    logic                    is_rom_c;
    logic                    trap_c;
    logic [16:0]             rom_addr_c;
    logic                    ram_we;

    logic [15:0]             ram_mem [RAM_DEPTH];
    logic [15:0]             ram_rd_q;

    // Region decode of the live bus address. ROM_L wins over any overlap.
    always_comb begin
        region_c = R_UNMAP;
        if (addr[22:17] == 6'd0) begin
            region_c = R_ROM_L;
        end else if ((addr[22:19] == 4'd0) && addr[18]) begin
            region_c = R_ROM_H;
        end else if (addr[22:RAM_AWIDTH] == RAM_BASE[22:RAM_AWIDTH]) begin
            region_c = R_RAM;
        end
    end

    assign is_rom_c   = (region_c == R_ROM_L) || (region_c == R_ROM_H);
    // The high ROM is only 4K words deep, so its upper address bits alias.
    assign rom_addr_c = (region_c == R_ROM_H) ? {5'b0, addr[11:0]} : addr[16:0];

`ifdef ROM_WRITE_TRAP_EN
    assign trap_c = (region_c == R_UNMAP) || (is_rom_c && !BR_W_b);
`else
    assign trap_c = (region_c == R_UNMAP);
`endif

    // Next-state and registered-output logic for the bus cycle FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        region_d    = region_q;
        rnw_d       = rnw_q;
        uds_d       = uds_q;
        lds_d       = lds_q;
        wdata_d     = wdata_q;
        ram_idx_d   = ram_idx_q;
        dtack_b_d   = dtack_b_q;
        berr_b_d    = berr_b_q;
        data_out_d  = data_out_q;
        rom_en_d    = rom_en_q;
        rom_addr_d  = rom_addr_q;
        rom_sel_h_d = rom_sel_h_q;
        ram_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!AS_b) begin
                    region_d  = region_c;
                    rnw_d     = BR_W_b;
                    uds_d     = UDS_b;
                    lds_d     = LDS_b;
                    wdata_d   = DATA_in;
                    ram_idx_d = addr[RAM_AWIDTH-1:0];
                    if (is_rom_c) begin
                        rom_addr_d  = rom_addr_c;
                        rom_sel_h_d = (region_c == R_ROM_H);
                    end
                    if (trap_c) begin
                        state_d = S_ERR;
                        cnt_d   = CNT_W'(TIMEOUT);
                    end else begin
                        state_d  = S_WAIT;
                        cnt_d    = is_rom_c ? CNT_W'(ROM_WAIT) : CNT_W'(RAM_WAIT);
                        rom_en_d = is_rom_c;
                    end
                end
            end

            // The counter runs down to zero and ACK follows one edge later, so
            // DTACK_b falls N+1 edges after the start edge.
            S_WAIT: begin
                if (AS_b) begin
                    state_d  = S_IDLE;
                    rom_en_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d   = S_ACK;
                    dtack_b_d = 1'b0;
                    rom_en_d  = 1'b0;
                    if (rnw_q) begin
                        data_out_d = (region_q == R_RAM) ? ram_rd_q : rom_data;
                    end else if (region_q == R_RAM) begin
                        ram_we = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_ACK: begin
                if (AS_b) begin
                    state_d   = S_IDLE;
                    dtack_b_d = 1'b1;
                end
            end

            S_ERR: begin
                if (AS_b) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d  = S_BERR;
                    berr_b_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_BERR: begin
                if (AS_b) begin
                    state_d  = S_IDLE;
                    berr_b_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge MCKR) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            region_q    <= R_UNMAP;
            rnw_q       <= 1'b1;
            uds_q       <= 1'b1;
            lds_q       <= 1'b1;
            wdata_q     <= 16'h0000;
            ram_idx_q   <= '0;
            dtack_b_q   <= 1'b1;
            berr_b_q    <= 1'b1;
            data_out_q  <= 16'h0000;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= 17'h00000;
            rom_sel_h_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            region_q    <= region_d;
            rnw_q       <= rnw_d;
            uds_q       <= uds_d;
            lds_q       <= lds_d;
            wdata_q     <= wdata_d;
            ram_idx_q   <= ram_idx_d;
            dtack_b_q   <= dtack_b_d;
            berr_b_q    <= berr_b_d;
            data_out_q  <= data_out_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            rom_sel_h_q <= rom_sel_h_d;
        end
    end

    // Work RAM: byte-masked write and a registered read. Because the index is
    // latched at the start edge, the read data is settled well before ACK entry.
    always_ff @(posedge MCKR) begin
        if (ram_we && !reset) begin
            if (!uds_q) begin
                ram_mem[ram_idx_q][15:8] <= wdata_q[15:8];
            end
            if (!lds_q) begin
                ram_mem[ram_idx_q][7:0] <= wdata_q[7:0];
            end
        end
        ram_rd_q <= ram_mem[ram_idx_q];
    end

    assign DATA_out  = data_out_q;
    assign DTACK_b   = dtack_b_q;
    assign BERR_b    = berr_b_q;
    assign rom_addr  = rom_addr_q;
    assign rom_sel_h = rom_sel_h_q;
    assign rom_en    = rom_en_q;

endmodule

// File: tb/tb_m68k_mem_responder.sv
// Directed testbench for m68k_mem_responder (ROM_WAIT=1, RAM_WAIT=3, TIMEOUT=64).
// A small ROM BRAM stub answers one cycle after rom_en.
// Edge counts are measured from the start edge, where AS_b is first sampled low,
// to the edge on which DTACK_b or BERR_b falls.

module tb_m68k_mem_responder;

    logic        MCKR = 1'b0;
    logic        reset;
    logic [22:0] addr;
    logic        AS_b;
    logic        UDS_b;
    logic        LDS_b;
    logic        BR_W_b;
    logic [15:0] DATA_in;
    logic [15:0] DATA_out;
    logic        DTACK_b;
    logic        BERR_b;
    logic [16:0] rom_addr;
    logic        rom_sel_h;
    logic        rom_en;
    logic [15:0] rom_data;

    int checks = 0;
    int errors = 0;

    m68k_mem_responder #(
        .ROM_WAIT   (1),
        .RAM_WAIT   (3),
        .RAM_BASE   (23'h200000),
        .RAM_AWIDTH (12),
        .TIMEOUT    (64)
    ) dut (
        .MCKR      (MCKR),
        .reset     (reset),
        .addr      (addr),
        .AS_b      (AS_b),
        .UDS_b     (UDS_b),
        .LDS_b     (LDS_b),
        .BR_W_b    (BR_W_b),
        .DATA_in   (DATA_in),
        .DATA_out  (DATA_out),
        .DTACK_b   (DTACK_b),
        .BERR_b    (BERR_b),
        .rom_addr  (rom_addr),
        .rom_sel_h (rom_sel_h),
        .rom_en    (rom_en),
        .rom_data  (rom_data)
    );

    always #5 MCKR = ~MCKR;

    // ROM BRAM stub: low ROM word 0x10 holds 0x4EF9; high ROM returns 0x8000 | index.
    always_ff @(posedge MCKR) begin
        if (rom_en) begin
            if (rom_sel_h) begin
                rom_data <= 16'h8000 | {4'h0, rom_addr[11:0]};
            end else if (rom_addr == 17'h00010) begin
                rom_data <= 16'h4EF9;
            end else begin
                rom_data <= rom_addr[15:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Run one full bus cycle. The caller is always 1 time unit after a posedge.
    task automatic bus_cycle(input logic [22:0] a, input logic rnw, input logic u,
                             input logic l, input logic [15:0] wd,
                             output int edges, output logic [15:0] rd,
                             output logic dt_at, output logic be_at,
                             output logic dt_rel, output logic be_rel);
        addr    = a;
        BR_W_b  = rnw;
        UDS_b   = u;
        LDS_b   = l;
        DATA_in = wd;
        AS_b    = 1'b0;
        @(posedge MCKR); #1;
        edges = 0;
        while (DTACK_b && BERR_b && edges < 200) begin
            @(posedge MCKR); #1;
            edges++;
        end
        rd    = DATA_out;
        dt_at = DTACK_b;
        be_at = BERR_b;
        AS_b  = 1'b1;
        @(posedge MCKR); #1;
        dt_rel = DTACK_b;
        be_rel = BERR_b;
        @(posedge MCKR); #1;
    endtask

    initial begin
        int          n;
        logic [15:0] rd;
        logic        dt, be, dtr, ber;

        reset = 1'b1; addr = '0; AS_b = 1'b1; UDS_b = 1'b1; LDS_b = 1'b1;
        BR_W_b = 1'b1; DATA_in = '0;
        repeat (2) @(posedge MCKR);
        #1;
        reset = 1'b0;

        chk("rst_dtack", 32'(DTACK_b), 32'h1);
        chk("rst_berr", 32'(BERR_b), 32'h1);
        chk("rst_data", 32'(DATA_out), 32'h0);
        chk("rst_rom_en", 32'(rom_en), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_rom_sel", 32'(rom_sel_h), 32'h0);

        // Low ROM read
        bus_cycle(23'h000010, 1'b1, 1'b0, 1'b0, 16'h0, n, rd, dt, be, dtr, ber);
        chk("roml_edges", 32'(n), 32'd2);
        chk("roml_dtack", 32'(dt), 32'h0);
        chk("roml_data", 32'(rd), 32'h4EF9);
        chk("roml_sel", 32'(rom_sel_h), 32'h0);
        chk("roml_addr", 32'(rom_addr), 32'h00010);
        chk("roml_release", 32'(dtr), 32'h1);
        chk("roml_hold_data", 32'(DATA_out), 32'h4EF9);
        chk("roml_rom_en_off", 32'(rom_en), 32'h0);

        // High ROM read
        bus_cycle(23'h040123, 1'b1, 1'b0, 1'b0, 16'h0, n, rd, dt, be, dtr, ber);
        chk("romh_edges", 32'(n), 32'd2);
        chk("romh_data", 32'(rd), 32'h8123);
        chk("romh_sel", 32'(rom_sel_h), 32'h1);
        chk("romh_addr", 32'(rom_addr), 32'h00123);
        chk("romh_release", 32'(dtr), 32'h1);

        // RAM byte-strobe writes and readback
        bus_cycle(23'h200005, 1'b0, 1'b0, 1'b0, 16'h0000, n, rd, dt, be, dtr, ber);
        chk("ram_clr_edges", 32'(n), 32'd4);
        chk("ram_clr_dtack", 32'(dt), 32'h0);
        bus_cycle(23'h200005, 1'b0, 1'b0, 1'b1, 16'hABCD, n, rd, dt, be, dtr, ber);
        chk("ram_wu_edges", 32'(n), 32'd4);
        bus_cycle(23'h200005, 1'b1, 1'b0, 1'b0, 16'h0, n, rd, dt, be, dtr, ber);
        chk("ram_rd_upper", 32'(rd), 32'hAB00);
        chk("ram_rd_edges", 32'(n), 32'd4);
        bus_cycle(23'h200005, 1'b0, 1'b1, 1'b0, 16'h1234, n, rd, dt, be, dtr, ber);
        bus_cycle(23'h200005, 1'b1, 1'b0, 1'b0, 16'h0, n, rd, dt, be, dtr, ber);
        chk("ram_rd_lower", 32'(rd), 32'hAB34);
        bus_cycle(23'h200005, 1'b0, 1'b1, 1'b1, 16'hFFFF, n, rd, dt, be, dtr, ber);
        chk("ram_nostrobe_dtack", 32'(dt), 32'h0);
        bus_cycle(23'h200006, 1'b0, 1'b0, 1'b0, 16'h5A5A, n, rd, dt, be, dtr, ber);
        bus_cycle(23'h200005, 1'b1, 1'b0, 1'b0, 16'h0, n, rd, dt, be, dtr, ber);
        chk("ram_nostrobe_keep", 32'(rd), 32'hAB34);
        bus_cycle(23'h200006, 1'b1, 1'b0, 1'b0, 16'h0, n, rd, dt, be, dtr, ber);
        chk("ram_neighbour", 32'(rd), 32'h5A5A);

        // Unmapped read: bus error after the timeout
        bus_cycle(23'h7F0000, 1'b1, 1'b0, 1'b0, 16'h0, n, rd, dt, be, dtr, ber);
        chk("unmap_edges", 32'(n), 32'd65);
        chk("unmap_dtack", 32'(dt), 32'h1);
        chk("unmap_berr", 32'(be), 32'h0);
        chk("unmap_berr_rel", 32'(ber), 32'h1);
        chk("unmap_dtack_rel", 32'(dtr), 32'h1);

        // First word past the work RAM is unmapped
        bus_cycle(23'h201000, 1'b1, 1'b0, 1'b0, 16'h0, n, rd, dt, be, dtr, ber);
        chk("ram_end_edges", 32'(n), 32'd65);
        chk("ram_end_berr", 32'(be), 32'h0);

        // ROM write
        bus_cycle(23'h000000, 1'b0, 1'b0, 1'b0, 16'hDEAD, n, rd, dt, be, dtr, ber);
`ifdef ROM_WRITE_TRAP_EN
        chk("romwr_edges", 32'(n), 32'd65);
        chk("romwr_dtack", 32'(dt), 32'h1);
        chk("romwr_berr", 32'(be), 32'h0);
        chk("romwr_berr_rel", 32'(ber), 32'h1);
`else
        chk("romwr_edges", 32'(n), 32'd2);
        chk("romwr_dtack", 32'(dt), 32'h0);
        chk("romwr_berr", 32'(be), 32'h1);
`endif

        // Abort a RAM write during its wait states
        addr = 23'h200005; BR_W_b = 1'b0; UDS_b = 1'b0; LDS_b = 1'b0;
        DATA_in = 16'h5555; AS_b = 1'b0;
        @(posedge MCKR); #1;
        @(posedge MCKR); #1;
        chk("abort_wait_dtack", 32'(DTACK_b), 32'h1);
        AS_b = 1'b1;
        repeat (5) @(posedge MCKR);
        #1;
        chk("abort_no_dtack", 32'(DTACK_b), 32'h1);
        chk("abort_no_berr", 32'(BERR_b), 32'h1);
        bus_cycle(23'h200005, 1'b1, 1'b0, 1'b0, 16'h0, n, rd, dt, be, dtr, ber);
        chk("abort_ram_keep", 32'(rd), 32'hAB34);
        chk("abort_idle_edges", 32'(n), 32'd4);

        // Abort an unmapped access before the timeout
        addr = 23'h7F0000; BR_W_b = 1'b1; AS_b = 1'b0;
        @(posedge MCKR); #1;
        repeat (10) @(posedge MCKR);
        #1;
        AS_b = 1'b1;
        repeat (70) @(posedge MCKR);
        #1;
        chk("abort_err_berr", 32'(BERR_b), 32'h1);
        chk("abort_err_dtack", 32'(DTACK_b), 32'h1);

        // Reset on the edge where the RAM write would commit
        addr = 23'h200005; BR_W_b = 1'b0; UDS_b = 1'b0; LDS_b = 1'b0;
        DATA_in = 16'hFFFF; AS_b = 1'b0;
        @(posedge MCKR); #1;
        repeat (3) @(posedge MCKR);
        #1;
        chk("rstwr_pre_dtack", 32'(DTACK_b), 32'h1);
        reset = 1'b1; AS_b = 1'b1;
        @(posedge MCKR); #1;
        chk("rstwr_dtack", 32'(DTACK_b), 32'h1);
        reset = 1'b0;
        @(posedge MCKR); #1;
        bus_cycle(23'h200005, 1'b1, 1'b0, 1'b0, 16'h0, n, rd, dt, be, dtr, ber);
        chk("rstwr_ram_keep", 32'(rd), 32'hAB34);

        // Reset while in ACK
        addr = 23'h200006; BR_W_b = 1'b1; AS_b = 1'b0;
        @(posedge MCKR); #1;
        n = 0;
        while (DTACK_b && n < 200) begin
            @(posedge MCKR); #1;
            n++;
        end
        chk("rstack_edges", 32'(n), 32'd4);
        chk("rstack_data", 32'(DATA_out), 32'h5A5A);
        reset = 1'b1;
        @(posedge MCKR); #1;
        chk("rstack_dtack", 32'(DTACK_b), 32'h1);
        chk("rstack_dout", 32'(DATA_out), 32'h0);
        reset = 1'b0; AS_b = 1'b1;
        repeat (2) @(posedge MCKR);
        #1;
        bus_cycle(23'h200006, 1'b1, 1'b0, 1'b0, 16'h0, n, rd, dt, be, dtr, ber);
        chk("rstack_ram_keep", 32'(rd), 32'h5A5A);
        chk("rstack_after_dtack", 32'(dt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m68k_mem_responder.md
Name: m68k_mem_responder

Overview:
- 68000-style bus slave that serves CPU cycles against low program ROM, high program ROM and on-chip work RAM.
- Decodes the address. Handles UDS_b/LDS_b byte strobes. Inserts programmable wait states. Returns DTACK_b, or BERR_b for unmapped addresses.
- Sits between the CPU core inside graphics and the ROM BRAMs. Replaces the free-running registered ROM fetch with a handshaked responder.
- Runs entirely on MCKR.

Parameters:
- ROM_WAIT, 1: wait cycles before DTACK for ROM regions. Minimum 1, to cover the BRAM read latency.
- RAM_WAIT, 1: wait cycles before DTACK for the work RAM. Minimum 1.
- RAM_BASE, 23'h200000: word address of the work RAM base (byte 0x400000).
- RAM_AWIDTH, 12: work RAM depth is 2^RAM_AWIDTH 16-bit words.
- TIMEOUT, 64: cycles an unmapped access waits before BERR_b asserts.

Ports:
- MCKR  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- addr  input  23  CPU word address A23..A1.
- AS_b  input  1  address strobe, active low.
- UDS_b  input  1  upper byte strobe (D15..D8), active low.
- LDS_b  input  1  lower byte strobe (D7..D0), active low.
- BR_W_b  input  1  1 = read, 0 = write.
- DATA_in  input  16  CPU write data.
- DATA_out  output  16  read data to CPU; registered.
- DTACK_b  output  1  data acknowledge, active low.
- BERR_b  output  1  bus error, active low.
- rom_addr  output  17  word index into the selected ROM BRAM.
- rom_sel_h  output  1  1 = high ROM, 0 = low ROM.
- rom_en  output  1  ROM BRAM read enable.
- rom_data  input  16  ROM BRAM output, valid 1 cycle after rom_en.

Behaviour:
- Clock and reset: one clock, MCKR. reset is synchronous and active-high.
- Reset values: state IDLE, DTACK_b=1, BERR_b=1, DATA_out=16'h0000, rom_en=0, rom_addr=0, rom_sel_h=0. RAM contents are not cleared.
- Address decode, from the latched addr:
  - ROM_L: addr[22:17]==0. rom_addr=addr[16:0], rom_sel_h=0.
  - ROM_H: addr[22:19]==0 and addr[18]==1. rom_addr={5'b0, addr[11:0]}, rom_sel_h=1.
  - RAM: addr[22:RAM_AWIDTH]==RAM_BASE[22:RAM_AWIDTH]. Index is addr[RAM_AWIDTH-1:0].
  - Anything else is UNMAPPED. ROM_L takes priority over RAM if the regions overlap.
- IDLE:
  - On a posedge with AS_b==0, latch addr, BR_W_b, UDS_b, LDS_b, DATA_in and the region.
  - Go to WAIT, loading the wait counter with ROM_WAIT or RAM_WAIT.
  - For an UNMAPPED region, go to ERR with the counter set to TIMEOUT.
- WAIT:
  - Counter decrements each cycle.
  - For ROM regions, rom_en=1 for every WAIT cycle.
  - When the counter reaches 0, go to ACK.
  - DTACK_b falls exactly N+1 MCKR edges after the start edge, where N is the region's wait count.
- ACK entry:
  - Read: DATA_out is loaded with rom_data or RAM[index].
  - RAM write: byte 15:8 is written if UDS_b==0; byte 7:0 is written if LDS_b==0. Both strobes high means no write, but DTACK is still given.
  - ROM write: ignored, with a normal DTACK.
- ACK:
  - DTACK_b=0. DATA_out holds its value.
  - Stay in ACK until AS_b is sampled 1, then go to IDLE. DTACK_b=1 on that same edge.
  - A back-to-back cycle needs AS_b high for at least 1 sampled edge.
- ERR:
  - Count down TIMEOUT cycles, then assert BERR_b=0.
  - Hold until AS_b is sampled 1, then go to IDLE with BERR_b=1. DTACK_b is never asserted.
- Abort: if AS_b is sampled 1 in WAIT or in ERR before the timeout, go to IDLE. No DTACK, no BERR, no RAM write.
- Reset mid-cycle: immediate return to IDLE with reset values. A pending write is dropped.
- DATA_out holds its last read value outside ACK.
- Inputs are already in the MCKR domain; no synchronizers.

Optional Feature:
- Macro: ROM_WRITE_TRAP_EN.
- When defined: a write to ROM_L or ROM_H takes the ERR path (TIMEOUT cycles, then BERR_b=0) instead of a silent DTACK.
- When undefined: ROM writes are acknowledged and discarded.

Test Plan:
- Reset, then read addr=23'h000010 with ROM_WAIT=1 and the BRAM returning 16'h4EF9 -> DTACK_b low on the 2nd edge after AS_b falls, DATA_out=16'h4EF9, rom_sel_h=0, rom_addr=17'h00010.
- Read addr=23'h040123 -> rom_sel_h=1, rom_addr=17'h00123. After AS_b rises, DTACK_b=1 on the next edge.
- Write 16'hABCD to RAM_BASE+5 with UDS_b=0, LDS_b=1, then read it back; the word was 16'h0000 -> read returns 16'hAB00. Repeat with LDS_b only, writing 16'h1234 -> read returns 16'hAB34.
- Read addr=23'h7F0000 (unmapped), TIMEOUT=64 -> DTACK_b stays 1, BERR_b=0 after 64 WAIT cycles, BERR_b=1 one edge after AS_b rises. With ROM_WRITE_TRAP_EN defined, a write to addr=23'h000000 produces the same BERR_b sequence.
- Start a RAM write with RAM_WAIT=3 and raise AS_b after 1 cycle -> no DTACK, the RAM word is unchanged, state returns to IDLE.
- Assert reset during ACK -> DTACK_b=1 and DATA_out=0 on the next edge. A RAM word written earlier still reads back its value after reset.
